sv_timer_bank: RTL and testbench

Parametrised successor to the system-register timer/NMI logic in the console top level. It provides NUM_TIMERS independent down-counting interval timers that share one free-running prescaler. Each timer has its own tap select, auto-reload mode, IRQ enable and pending flag. The block also generates the periodic NMI with a hold-latch that keeps pulses from being lost while the CPU is stalled by DMA. It sits on the system-register bus beside the DMA, audio and LCD units and drives the CPU irq_n/nmi_n inputs.

---
 rtl/sv_timer_pkg.sv | 62 ++++++
 rtl/sv_timer_chan.sv | 91 +++++++++
 rtl/sv_timer_bank.sv | 113 +++++++++++
 tb/tb_sv_timer_bank.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sv_timer_pkg.sv
// Shared definitions for the timer bank: register map helpers, CTRL layout.
package sv_timer_pkg;

  localparam int unsigned CTRL_IRQ_EN_BIT  = 0;
  localparam int unsigned CTRL_TAP_SEL_BIT = 1;
  localparam int unsigned CTRL_AUTO_BIT    = 2;

  // Field order makes bit0 = irq_en when the struct is cast to a byte.
  typedef struct packed {
    logic auto_reload;
    logic tap_sel;
    logic irq_en;
  } timer_ctrl_t;

  typedef enum logic [2:0] {
    RK_LEN,
    RK_CTRL,
    RK_STATUS,
    RK_GCTL,
    RK_NONE
  } reg_kind_t;

  typedef struct packed {
    reg_kind_t  kind;
    logic [2:0] idx;
  } reg_dec_t;

  function automatic logic [3:0] len_addr(int unsigned i);
    return 4'(2 * i);
  endfunction

  function automatic logic [3:0] ctrl_addr(int unsigned i);
    return 4'(2 * i + 1);
  endfunction

  function automatic logic [3:0] status_addr(int unsigned n);
    return 4'(2 * n);
  endfunction

  function automatic logic [3:0] gctl_addr(int unsigned n);
    return 4'(2 * n + 1);
  endfunction

  function automatic reg_dec_t decode_addr(logic [3:0] addr, int unsigned n);
    reg_dec_t d;
    d.idx  = addr[3:1];
    d.kind = RK_NONE;
    if (32'(addr[3:1]) < n)            d.kind = addr[0] ? RK_CTRL : RK_LEN;
    else if (addr == status_addr(n))   d.kind = RK_STATUS;
    else if (addr == gctl_addr(n))     d.kind = RK_GCTL;
    return d;
  endfunction

  function automatic timer_ctrl_t ctrl_from_byte(logic [7:0] b);
    timer_ctrl_t c;
    c.irq_en      = b[CTRL_IRQ_EN_BIT];
    c.tap_sel     = b[CTRL_TAP_SEL_BIT];
    c.auto_reload = b[CTRL_AUTO_BIT];
    return c;
  endfunction

endpackage

// File: rtl/sv_timer_chan.sv
// One down-counting interval timer channel with deferred IRQ raise.
module sv_timer_chan
  import sv_timer_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             ce,
  input  logic             tap_fast_i,
  input  logic             tap_slow_i,
  input  logic             len_we_i,
  input  logic [CNT_W-1:0] len_wdata_i,
  input  logic             ctrl_we_i,
  input  timer_ctrl_t      ctrl_wdata_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] counter_o,
  output timer_ctrl_t      ctrl_o,
  output logic             pending_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] rel_q, rel_d;
  timer_ctrl_t      ctrl_q, ctrl_d;
  logic             armed_q, armed_d;
  logic             pend_q, pend_d;
  logic             old_tap_q;
  logic             tap;
  logic             set_pend;

  // Next-state: expiry arms on the tap high phase, pending is raised once the tap drops.
  always_comb begin
    tap      = ctrl_q.tap_sel ? tap_slow_i : tap_fast_i;
    cnt_d    = cnt_q;
    rel_d    = rel_q;
    ctrl_d   = ctrl_q;
    armed_d  = armed_q;
    set_pend = 1'b0;

    if (armed_q && !tap) begin
      set_pend = 1'b1;
      armed_d  = 1'b0;
    end

    // A LEN write takes priority over a coincident tap edge.
    if (len_we_i) begin
      cnt_d = len_wdata_i;
      rel_d = len_wdata_i;
      if (len_wdata_i == '0) begin
        if (!tap) set_pend = 1'b1;
        else      armed_d  = 1'b1;
      end
    end else if (tap && !old_tap_q && (cnt_q != '0)) begin
      if (cnt_q == CNT_W'(1)) begin
        armed_d = 1'b1;
        cnt_d   = (ctrl_q.auto_reload && (rel_q != '0)) ? rel_q : '0;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end

    if (ctrl_we_i) ctrl_d = ctrl_wdata_i;

    // Set beats a simultaneous W1C.
    pend_d = set_pend | (pend_q & ~clr_i);
  end

  // Channel state registers, advanced only on bus-phase strobe.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cnt_q     <= '0;
      rel_q     <= '0;
      ctrl_q    <= '0;
      armed_q   <= 1'b0;
      pend_q    <= 1'b0;
      old_tap_q <= 1'b0;
    end else if (ce) begin
      cnt_q     <= cnt_d;
      rel_q     <= rel_d;
      ctrl_q    <= ctrl_d;
      armed_q   <= armed_d;
      pend_q    <= pend_d;
      old_tap_q <= tap;
    end
  end

  assign counter_o = cnt_q;
  assign ctrl_o    = ctrl_q;
  assign pending_o = pend_q;

endmodule

// File: rtl/sv_timer_bank.sv
// Timer bank top: shared prescaler, register decode/readback, IRQ and NMI generation.
module sv_timer_bank
  import sv_timer_pkg::*;
#(
  parameter int unsigned NUM_TIMERS = 2,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned PRESC_W    = 16,
  parameter int unsigned FAST_TAP   = 7,
  parameter int unsigned SLOW_TAP   = 13
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic               ce,
  input  logic               hold,
  input  logic               reg_cs,
  input  logic               reg_we,
  input  logic [3:0]         reg_addr,
  input  logic [7:0]         reg_wdata,
  output logic [7:0]         reg_rdata,
  output logic               irq_n,
  output logic               nmi_n,
  output logic [PRESC_W-1:0] prescaler
);

  logic [PRESC_W-1:0]    presc_q;
  logic                  msb_old_q;
  logic                  nmi_latch_q;
  logic                  nmi_en_q;
  logic                  irq_n_q;
  logic                  nmi_pulse;
  logic                  bus_wr;
  reg_dec_t              dec;
  timer_ctrl_t           ctrl_wr;
  logic [NUM_TIMERS-1:0] clr_vec;
  logic [NUM_TIMERS-1:0] pend_vec;
  logic [NUM_TIMERS-1:0] irqen_vec;
  logic [CNT_W-1:0]      cnt_arr  [NUM_TIMERS];
  timer_ctrl_t           ctrl_arr [NUM_TIMERS];

  assign bus_wr  = reg_cs && reg_we;
  assign dec     = decode_addr(reg_addr, NUM_TIMERS);
  assign ctrl_wr = ctrl_from_byte(reg_wdata);
  assign clr_vec = (bus_wr && (dec.kind == RK_STATUS)) ? reg_wdata[NUM_TIMERS-1:0] : '0;

  for (genvar g = 0; g < NUM_TIMERS; g++) begin : g_chan
    logic len_we;
    logic ctrl_we;
    assign len_we       = bus_wr && (dec.kind == RK_LEN)  && (dec.idx == 3'(g));
    assign ctrl_we      = bus_wr && (dec.kind == RK_CTRL) && (dec.idx == 3'(g));
    assign irqen_vec[g] = ctrl_arr[g].irq_en;

    sv_timer_chan #(
      .CNT_W (CNT_W)
    ) u_chan (
      .clk_sys      (clk_sys),
      .reset        (reset),
      .ce           (ce),
      .tap_fast_i   (presc_q[FAST_TAP]),
      .tap_slow_i   (presc_q[SLOW_TAP]),
      .len_we_i     (len_we),
      .len_wdata_i  (reg_wdata[CNT_W-1:0]),
      .ctrl_we_i    (ctrl_we),
      .ctrl_wdata_i (ctrl_wr),
      .clr_i        (clr_vec[g]),
      .counter_o    (cnt_arr[g]),
      .ctrl_o       (ctrl_arr[g]),
      .pending_o    (pend_vec[g])
    );
  end

  // NMI pulse lasts from the MSB falling edge until the next ce.
  assign nmi_pulse = msb_old_q & ~presc_q[PRESC_W-1];

  // Prescaler, NMI latch/enable and registered IRQ summary.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      presc_q     <= '0;
      msb_old_q   <= 1'b0;
      nmi_latch_q <= 1'b0;
      nmi_en_q    <= 1'b0;
      irq_n_q     <= 1'b1;
    end else if (ce) begin
      presc_q     <= presc_q + PRESC_W'(1);
      msb_old_q   <= presc_q[PRESC_W-1];
      nmi_latch_q <= hold ? (nmi_latch_q | (nmi_pulse & nmi_en_q)) : 1'b0;
      irq_n_q     <= ~|(pend_vec & irqen_vec);
      if (bus_wr && (dec.kind == RK_GCTL)) nmi_en_q <= reg_wdata[0];
    end
  end

  // Combinational register readback.
  always_comb begin
    reg_rdata = 8'hFF;
    case (dec.kind)
      RK_LEN, RK_CTRL: begin
        reg_rdata = '0;
        for (int unsigned i = 0; i < NUM_TIMERS; i++) begin
          if (dec.idx == 3'(i)) begin
            reg_rdata = (dec.kind == RK_LEN) ? 8'(cnt_arr[i]) : 8'(ctrl_arr[i]);
          end
        end
      end
      RK_STATUS: reg_rdata = 8'(pend_vec);
      RK_GCTL:   reg_rdata = {7'd0, nmi_en_q};
      default:   reg_rdata = 8'hFF;
    endcase
  end

  assign irq_n     = irq_n_q;
  assign nmi_n     = ~((nmi_pulse | nmi_latch_q) & nmi_en_q);
  assign prescaler = presc_q;

endmodule

// File: tb/tb_sv_timer_bank.sv
// Self-checking bench for sv_timer_bank with a behavioural reference model.
module tb_sv_timer_bank;

  localparam int N    = 2;
  localparam int CW   = 8;
  localparam int PW   = 12;
  localparam int FT   = 3;
  localparam int ST   = 6;
  localparam int PMOD = 1 << PW;

  logic          clk = 1'b0;
  logic          reset, ce, hold, reg_cs, reg_we;
  logic [3:0]    reg_addr;
  logic [7:0]    reg_wdata, reg_rdata;
  logic          irq_n, nmi_n;
  logic [PW-1:0] prescaler;

  int n_vec, n_err;

  // Reference model state: number of ce's since reset stands in for the prescaler.
  int m_count;
  int m_cnt [N];
  int m_rel [N];
  bit m_irqen [N], m_tapsel [N], m_auto [N], m_armed [N], m_pend [N], m_prevtap [N];
  bit m_nmien, m_latch, m_prevmsb, m_irqn;

  sv_timer_bank #(
    .NUM_TIMERS (N),
    .CNT_W      (CW),
    .PRESC_W    (PW),
    .FAST_TAP   (FT),
    .SLOW_TAP   (ST)
  ) dut (
    .clk_sys   (clk),
    .reset     (reset),
    .ce        (ce),
    .hold      (hold),
    .reg_cs    (reg_cs),
    .reg_we    (reg_we),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .irq_n     (irq_n),
    .nmi_n     (nmi_n),
    .prescaler (prescaler)
  );

  always #5 clk = ~clk;

  function automatic bit m_tap(int i);
    int p;
    p = m_count % PMOD;
    return ((p >> (m_tapsel[i] ? ST : FT)) & 1) != 0;
  endfunction

  function automatic bit m_msb();
    return (((m_count % PMOD) >> (PW - 1)) & 1) != 0;
  endfunction

  function automatic bit m_nmin();
    bit pulse;
    pulse = m_prevmsb && !m_msb();
    return !((pulse || m_latch) && m_nmien);
  endfunction

  function automatic logic [7:0] m_read(int a);
    logic [7:0] s;
    s = 8'h00;
    if (a < 2 * N) begin
      if (a % 2 == 0) return 8'(m_cnt[a / 2]);
      return {5'd0, m_auto[a / 2], m_tapsel[a / 2], m_irqen[a / 2]};
    end
    if (a == 2 * N) begin
      for (int i = 0; i < N; i++) s[i] = m_pend[i];
      return s;
    end
    if (a == 2 * N + 1) return {7'd0, m_nmien};
    return 8'hFF;
  endfunction

  function automatic void model_step();
    bit any, wr, tap, set, pulse;
    logic [7:0] wd;
    if (reset) begin
      m_count = 0;
      for (int i = 0; i < N; i++) begin
        m_cnt[i] = 0; m_rel[i] = 0; m_irqen[i] = 0; m_tapsel[i] = 0;
        m_auto[i] = 0; m_armed[i] = 0; m_pend[i] = 0; m_prevtap[i] = 0;
      end
      m_nmien = 0; m_latch = 0; m_prevmsb = 0; m_irqn = 1;
      return;
    end
    if (!ce) return;
    wr = reg_cs && reg_we;
    wd = reg_wdata;
    any = 0;
    for (int i = 0; i < N; i++) any = any | (m_pend[i] && m_irqen[i]);
    m_irqn = !any;
    for (int i = 0; i < N; i++) begin
      tap = m_tap(i);
      set = 0;
      if (m_armed[i] && !tap) begin set = 1; m_armed[i] = 0; end
      if (wr && reg_addr == 4'(2 * i)) begin
        m_cnt[i] = int'(wd) % (1 << CW);
        m_rel[i] = m_cnt[i];
        if (m_cnt[i] == 0) begin
          if (!tap) set = 1; else m_armed[i] = 1;
        end
      end else if (tap && !m_prevtap[i] && m_cnt[i] > 0) begin
        m_cnt[i] = m_cnt[i] - 1;
        if (m_cnt[i] == 0) begin
          m_armed[i] = 1;
          if (m_auto[i] && m_rel[i] > 0) m_cnt[i] = m_rel[i];
        end
      end
      if (wr && reg_addr == 4'(2 * N) && wd[i]) m_pend[i] = 0;
      if (set) m_pend[i] = 1;
      if (wr && reg_addr == 4'(2 * i + 1)) begin
        m_irqen[i] = wd[0]; m_tapsel[i] = wd[1]; m_auto[i] = wd[2];
      end
      m_prevtap[i] = tap;
    end
    pulse = m_prevmsb && !m_msb();
    m_latch = hold ? (m_latch || (pulse && m_nmien)) : 0;
    if (wr && reg_addr == 4'(2 * N + 1)) m_nmien = wd[0];
    m_prevmsb = m_msb();
    m_count++;
  endfunction

  task automatic tick(input bit c, input bit cs, input bit we, input logic [3:0] a, input logic [7:0] d);
    ce = c; reg_cs = cs; reg_we = we; reg_addr = a; reg_wdata = d;
    @(posedge clk);
    model_step();
    #1;
  endtask

  function automatic bit rce();
    return $urandom_range(0, 3) != 0;
  endfunction

  task automatic idle(input bit c);
    tick(c, 1'b0, 1'b0, 4'h0, 8'h00);
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    tick(1'b1, 1'b1, 1'b1, a, d);
  endtask

  task automatic rd(input logic [3:0] a, output logic [7:0] v);
    tick(1'b1, 1'b1, 1'b0, a, 8'h00);
    v = reg_rdata;
  endtask

  task automatic test_reset();
    logic [7:0] v;
    reset = 1'b1; hold = 1'b0;
    repeat (3) idle(1'b1);
    reset = 1'b0;
    n_vec++; if (irq_n !== 1'b1) begin n_err++; $display("FAIL reset_irq_n got %b want 1", irq_n); end
    n_vec++; if (nmi_n !== 1'b1) begin n_err++; $display("FAIL reset_nmi_n got %b want 1", nmi_n); end
    n_vec++; if (prescaler !== '0) begin n_err++; $display("FAIL reset_presc got %0d want 0", prescaler); end
    for (int a = 0; a < 2 * N + 2; a++) begin
      rd(4'(a), v);
      n_vec++; if (v !== 8'h00) begin n_err++; $display("FAIL reset_reg%0d got %h want 00", a, v); end
    end
  endtask

  task automatic test_oneshot();
    logic [7:0] v;
    bit seen = 0;
    wr(4'd1, 8'h01);
    wr(4'd0, 8'h03);
    for (int k = 0; k < 300; k++) begin
      idle(rce());
      n_vec++; if (irq_n !== m_irqn) begin n_err++; $display("FAIL oneshot_irq got %b want %b", irq_n, m_irqn); end
      if (irq_n === 1'b0) begin seen = 1; break; end
    end
    n_vec++; if (!seen) begin n_err++; $display("FAIL oneshot_timeout got no irq want irq_n=0"); end
    rd(4'd4, v);
    n_vec++; if (v !== 8'h01) begin n_err++; $display("FAIL oneshot_status got %h want 01", v); end
    wr(4'd4, 8'h01);
    n_vec++; if (irq_n !== 1'b0) begin n_err++; $display("FAIL oneshot_irq_lat got %b want 0", irq_n); end
    idle(1'b1);
    n_vec++; if (irq_n !== 1'b1) begin n_err++; $display("FAIL oneshot_release got %b want 1", irq_n); end
  endtask

  task automatic test_autoreload();
    logic [7:0] v;
    bit done = 0;
    wr(4'd3, 8'h05);
    wr(4'd2, 8'h02);
    for (int k = 0; k < 600; k++) begin
      if (!done && m_armed[1] && !m_tap(1)) begin
        wr(4'd4, 8'h02);
        done = 1;
        rd(4'd4, v);
        n_vec++; if (v[1] !== 1'b1) begin n_err++; $display("FAIL ar_set_wins got %h want bit1=1", v); end
      end else if (m_pend[1]) begin
        wr(4'd4, 8'h02);
      end else if (k % 5 == 0) begin
        rd(4'd2, v);
        n_vec++; if (v !== m_read(2)) begin n_err++; $display("FAIL ar_count got %0d want %0d", v, m_read(2)); end
        n_vec++; if (v !== 8'd1 && v !== 8'd2) begin n_err++; $display("FAIL ar_range got %0d want 1 or 2", v); end
      end else begin
        idle(rce());
      end
      n_vec++; if (irq_n !== m_irqn) begin n_err++; $display("FAIL ar_irq got %b want %b", irq_n, m_irqn); end
    end
    n_vec++; if (!done) begin n_err++; $display("FAIL ar_coincide got none want one"); end
    wr(4'd3, 8'h00);
    wr(4'd2, 8'h01);
  endtask

  task automatic test_len_zero();
    logic [7:0] v;
    wr(4'd4, 8'h03);
    for (int k = 0; k < 40 && (m_count % 16) != 8; k++) idle(1'b1);
    wr(4'd0, 8'h00);
    rd(4'd4, v);
    n_vec++; if (v[0] !== 1'b0) begin n_err++; $display("FAIL lz_deferred got %h want bit0=0", v); end
    for (int k = 0; k < 40 && m_tap(0); k++) idle(1'b1);
    idle(1'b1);
    rd(4'd4, v);
    n_vec++; if (v[0] !== 1'b1) begin n_err++; $display("FAIL lz_raise got %h want bit0=1", v); end
    wr(4'd4, 8'h01);
    for (int k = 0; k < 40 && m_tap(0); k++) idle(1'b1);
    wr(4'd0, 8'h00);
    n_vec++; if (m_tap(0) !== 1'b1 && reg_rdata !== 8'h00) begin n_err++; $display("FAIL lz_len_read got %h want 00", reg_rdata); end
    rd(4'd4, v);
    n_vec++; if (v[0] !== 1'b1) begin n_err++; $display("FAIL lz_immediate got %h want bit0=1", v); end
    wr(4'd4, 8'h03);
  endtask

  task automatic test_nmi();
    wr(4'd5, 8'h01);
    for (int k = 0; k < PMOD + 8 && (m_count % PMOD) != PMOD - 3; k++) idle(1'b1);
    hold = 1'b1;
    for (int k = 0; k < 12; k++) begin
      idle(1'b1);
      n_vec++; if (nmi_n !== m_nmin()) begin n_err++; $display("FAIL nmi_track got %b want %b", nmi_n, m_nmin()); end
    end
    n_vec++; if (nmi_n !== 1'b0) begin n_err++; $display("FAIL nmi_latched got %b want 0", nmi_n); end
    hold = 1'b0;
    idle(1'b1);
    n_vec++; if (nmi_n !== 1'b1) begin n_err++; $display("FAIL nmi_release got %b want 1", nmi_n); end
    wr(4'd5, 8'h00);
    for (int k = 0; k < PMOD + 16; k++) begin
      hold = $urandom_range(0, 1) == 1;
      idle(1'b1);
      n_vec++;
      if (nmi_n !== 1'b1) begin n_err++; $display("FAIL nmi_disabled got %b want 1", nmi_n); break; end
    end
    hold = 1'b0;
  endtask

  task automatic test_two_timers();
    logic [7:0] v;
    wr(4'd4, 8'h03);
    wr(4'd1, 8'h00);
    wr(4'd3, 8'h03);
    wr(4'd0, 8'h02);
    wr(4'd2, 8'h01);
    for (int k = 0; k < 800; k++) begin
      if (k % 16 == 0) begin
        rd(4'd4, v);
        n_vec++; if (v !== m_read(4)) begin n_err++; $display("FAIL two_status got %h want %h", v, m_read(4)); end
      end else begin
        idle(rce());
      end
      n_vec++; if (irq_n !== m_irqn) begin n_err++; $display("FAIL two_irq got %b want %b", irq_n, m_irqn); end
      if (m_pend[0] && !m_pend[1]) begin
        n_vec++; if (irq_n !== 1'b1) begin n_err++; $display("FAIL two_masked got %b want 1", irq_n); end
      end
    end
    rd(4'd4, v);
    n_vec++; if (v !== 8'h03) begin n_err++; $display("FAIL two_final got %h want 03", v); end
    n_vec++; if (irq_n !== 1'b0) begin n_err++; $display("FAIL two_final_irq got %b want 0", irq_n); end
    wr(4'd4, 8'h03);
  endtask

  task automatic test_random();
    logic [3:0] a;
    logic [7:0] d;
    int op;
    bit c;
    for (int k = 0; k < 3000 && n_err < 50; k++) begin
      hold = $urandom_range(0, 7) == 0;
      c = rce();
      op = $urandom_range(0, 9);
      if (op < 6) begin
        idle(c);
      end else if (op < 8) begin
        a = 4'($urandom_range(0, 6));
        d = (a < 4 && a[0] == 1'b0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
        tick(c, 1'b1, 1'b1, a, d);
      end else begin
        a = 4'($urandom_range(0, 15));
        tick(c, 1'b1, 1'b0, a, 8'h00);
        n_vec++; if (reg_rdata !== m_read(int'(a))) begin n_err++; $display("FAIL rnd_read a=%0d got %h want %h", a, reg_rdata, m_read(int'(a))); end
      end
      n_vec++; if (irq_n !== m_irqn) begin n_err++; $display("FAIL rnd_irq got %b want %b", irq_n, m_irqn); end
      n_vec++; if (nmi_n !== m_nmin()) begin n_err++; $display("FAIL rnd_nmi got %b want %b", nmi_n, m_nmin()); end
      n_vec++; if (prescaler !== PW'(m_count % PMOD)) begin n_err++; $display("FAIL rnd_presc got %0d want %0d", prescaler, m_count % PMOD); end
    end
    hold = 1'b0;
  endtask

  task automatic test_reset_midcount();
    logic [7:0] v;
    wr(4'd1, 8'h01);
    wr(4'd0, 8'h05);
    wr(4'd3, 8'h01);
    wr(4'd2, 8'h05);
    repeat (30) idle(1'b1);
    reset = 1'b1;
    idle(1'b1);
    reset = 1'b0;
    for (int a = 0; a < 2 * N + 2; a++) begin
      rd(4'(a), v);
      n_vec++; if (v !== 8'h00) begin n_err++; $display("FAIL rst_mid_reg%0d got %h want 00", a, v); end
    end
    for (int k = 0; k < 400; k++) begin
      idle(1'b1);
      n_vec++;
      if (irq_n !== 1'b1) begin n_err++; $display("FAIL rst_mid_irq got %b want 1", irq_n); break; end
    end
    rd(4'hF, v);
    n_vec++; if (v !== 8'hFF) begin n_err++; $display("FAIL unmapped_f got %h want ff", v); end
    rd(4'h6, v);
    n_vec++; if (v !== 8'hFF) begin n_err++; $display("FAIL unmapped_6 got %h want ff", v); end
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    reset = 1'b1; hold = 1'b0; ce = 1'b0;
    reg_cs = 1'b0; reg_we = 1'b0; reg_addr = '0; reg_wdata = '0;
    test_reset();
    test_oneshot();
    test_autoreload();
    test_len_zero();
    test_nmi();
    test_two_timers();
    test_random();
    test_reset_midcount();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
